// File: rtl/pr_freeze_pkg.sv
// Shared types and constants for the PR region freeze controller.
//   state_t           : freeze sequencing states
//   FREEZE_RDATA_DFLT : read data returned to the host while the region is frozen
//   TIMER_W           : width of the shared handshake/drain timeout counter
package pr_freeze_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_STOP_REQ,
    ST_DRAIN,
    ST_FROZEN,
    ST_START_REQ
  } state_t;

  localparam logic [63:0] FREEZE_RDATA_DFLT = 64'hDEAD_F0F0_DEAD_F0F0;
  localparam int unsigned TIMER_W           = 17;

endpackage

// File: rtl/pr_handshake_timer.sv
// Loadable down-counter shared by all waiting states of the freeze controller.
//   clk      in  clock
//   reset_n  in  synchronous active-low reset
//   load     in  reload with LOAD_VAL (asserted in the first cycle of a state)
//   expired  out count reached zero and no reload pending
module pr_handshake_timer
  import pr_freeze_pkg::*;
#(
  parameter int unsigned LOAD_VAL = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic expired
);

  logic [TIMER_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TIMER_W'(LOAD_VAL);
    end else if (cnt != '0) begin
      cnt <= cnt - TIMER_W'(1);
    end
  end

  // Load occupies one cycle, so the owning state lasts LOAD_VAL+2 cycles.
  assign expired = !load && (cnt == '0);

endmodule

// File: rtl/pr_region_freeze_ctrl.sv
// Static-region freeze controller for a partially reconfigurable region.
// Sequences stop -> drain -> freeze -> (reconfigure) -> start and isolates
// the region control bus while frozen so host accesses always complete.
//   clk_clk, reset_reset_n            clock, synchronous active-low reset
//   freeze_req, unfreeze_req, pr_done  PR controller pulses
//   frozen, busy, timeout_err         status (timeout_err sticky until reset)
//   persona_reset_n                   reconfigurable region reset, low while frozen
//   pr_handshake_stop_*/start_*       region stop/start level handshakes
//   s_*                               host-facing Avalon-MM slave
//   m_*                               region-facing Avalon-MM master
module pr_region_freeze_ctrl
  import pr_freeze_pkg::*;
#(
  parameter int unsigned       DATA_W       = 64,
  parameter int unsigned       ADDR_W       = 16,
  parameter int unsigned       MAX_OUTST    = 16,
  parameter int unsigned       TIMEOUT_CYC  = 65535,
  parameter logic [DATA_W-1:0] FREEZE_RDATA = DATA_W'(FREEZE_RDATA_DFLT)
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                freeze_req,
  input  logic                unfreeze_req,
  input  logic                pr_done,
  output logic                frozen,
  output logic                busy,
  output logic                timeout_err,
  output logic                persona_reset_n,
  output logic                pr_handshake_stop_req,
  input  logic                pr_handshake_stop_ack,
  output logic                pr_handshake_start_req,
  input  logic                pr_handshake_start_ack,
  output logic                s_waitrequest,
  output logic [DATA_W-1:0]   s_readdata,
  output logic                s_readdatavalid,
  input  logic [ADDR_W-1:0]   s_address,
  input  logic [DATA_W-1:0]   s_writedata,
  input  logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_read,
  input  logic                s_write,
  input  logic [0:0]          s_burstcount,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_read,
  output logic                m_write,
  output logic [0:0]          m_burstcount
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

  state_t           state;
  logic             tmr_load;
  logic             tmr_expired;
  logic             done_flag;
  logic             frz_rvalid;
  logic [CNT_W-1:0] outst;
  logic             outst_full;
  logic             pass;
  logic             fwd;
  logic             rd_inc;
  logic             rd_dec;

  pr_handshake_timer #(
    .LOAD_VAL (TIMEOUT_CYC - 2)
  ) u_timer (
    .clk     (clk_clk),
    .reset_n (reset_reset_n),
    .load    (tmr_load),
    .expired (tmr_expired)
  );

  // Sequencer. tmr_load pulses on every state entry. A request is only raised
  // once the matching ack has been seen low, so a stale ack is never taken.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state                  <= ST_RUN;
      tmr_load               <= 1'b0;
      done_flag              <= 1'b0;
      frozen                 <= 1'b0;
      busy                   <= 1'b0;
      timeout_err            <= 1'b0;
      persona_reset_n        <= 1'b1;
      pr_handshake_stop_req  <= 1'b0;
      pr_handshake_start_req <= 1'b0;
    end else begin
      tmr_load <= 1'b0;
      unique case (state)
        ST_RUN: begin
          if (freeze_req) begin
            state                 <= ST_STOP_REQ;
            tmr_load              <= 1'b1;
            busy                  <= 1'b1;
            pr_handshake_stop_req <= !pr_handshake_stop_ack;
          end
        end
        ST_STOP_REQ: begin
          if ((pr_handshake_stop_req && pr_handshake_stop_ack) || tmr_expired) begin
            if (!(pr_handshake_stop_req && pr_handshake_stop_ack))
              timeout_err <= 1'b1;
            state                 <= ST_DRAIN;
            tmr_load              <= 1'b1;
            pr_handshake_stop_req <= 1'b0;
          end else if (!pr_handshake_stop_ack) begin
            pr_handshake_stop_req <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (outst == '0 || tmr_expired) begin
            if (outst != '0)
              timeout_err <= 1'b1;
            state           <= ST_FROZEN;
            frozen          <= 1'b1;
            busy            <= 1'b0;
            persona_reset_n <= 1'b0;
            done_flag       <= 1'b0;
          end
        end
        ST_FROZEN: begin
          if (pr_done)
            done_flag <= 1'b1;
          if (unfreeze_req && done_flag) begin
            state                  <= ST_START_REQ;
            tmr_load               <= 1'b1;
            frozen                 <= 1'b0;
            busy                   <= 1'b1;
            persona_reset_n        <= 1'b1;
            done_flag              <= 1'b0;
            pr_handshake_start_req <= !pr_handshake_start_ack;
          end
        end
        ST_START_REQ: begin
          if ((pr_handshake_start_req && pr_handshake_start_ack) || tmr_expired) begin
            if (!(pr_handshake_start_req && pr_handshake_start_ack))
              timeout_err <= 1'b1;
            state                  <= ST_RUN;
            busy                   <= 1'b0;
            pr_handshake_start_req <= 1'b0;
          end else if (!pr_handshake_start_ack) begin
            pr_handshake_start_req <= 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign pass       = (state == ST_RUN);
  // Responses to reads issued before the freeze still reach the host while
  // stopping/draining; anything arriving later is dropped.
  assign fwd        = (state == ST_RUN) || (state == ST_STOP_REQ) || (state == ST_DRAIN);
  assign outst_full = (outst == CNT_W'(MAX_OUTST));

  assign m_address    = s_address;
  assign m_writedata  = s_writedata;
  assign m_byteenable = s_byteenable;
  assign m_burstcount = s_burstcount;
  assign m_read       = pass && s_read && !outst_full;
  assign m_write      = pass && s_write;

  always_comb begin
    s_waitrequest = 1'b1;
    unique case (state)
      ST_RUN:    s_waitrequest = m_waitrequest || (s_read && outst_full);
      ST_FROZEN: s_waitrequest = 1'b0;
      default:   s_waitrequest = 1'b1;
    endcase
  end

  assign s_readdatavalid = frz_rvalid || (fwd && m_readdatavalid);
  assign s_readdata      = frz_rvalid ? FREEZE_RDATA : m_readdata;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n)
      frz_rvalid <= 1'b0;
    else
      frz_rvalid <= (state == ST_FROZEN) && s_read;
  end

  // Decrement is guarded so a late response after a forced drain cannot wrap.
  assign rd_inc = m_read && !m_waitrequest;
  assign rd_dec = m_readdatavalid && (outst != '0);

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      outst <= '0;
    end else if (state == ST_DRAIN && tmr_expired) begin
      outst <= '0;
    end else if (rd_inc && !rd_dec) begin
      outst <= outst + CNT_W'(1);
    end else if (!rd_inc && rd_dec) begin
      outst <= outst - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pr_region_freeze_ctrl.sv
// Bench for pr_region_freeze_ctrl: host driver, region memory responder,
// scoreboard of expected host read data, and directed sequencing checks.
module tb_pr_region_freeze_ctrl;

  localparam logic [63:0] FRZ = 64'hDEAD_F0F0_DEAD_F0F0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        freeze_req = 1'b0, unfreeze_req = 1'b0, pr_done = 1'b0;
  logic        frozen, busy, timeout_err, persona_reset_n;
  logic        stop_req, start_req;
  logic        stop_ack = 1'b0, start_ack = 1'b0;
  logic        s_waitrequest, s_readdatavalid;
  logic [63:0] s_readdata;
  logic [15:0] s_address = '0;
  logic [63:0] s_writedata = '0;
  logic [7:0]  s_byteenable = '1;
  logic        s_read = 1'b0, s_write = 1'b0;
  logic [0:0]  s_burstcount = 1'b1;
  logic        m_waitrequest = 1'b0, m_readdatavalid = 1'b0;
  logic [63:0] m_readdata = '0;
  logic [15:0] m_address;
  logic [63:0] m_writedata;
  logic [7:0]  m_byteenable;
  logic        m_read, m_write;
  logic [0:0]  m_burstcount;

  pr_region_freeze_ctrl #(
    .DATA_W      (64),
    .ADDR_W      (16),
    .MAX_OUTST   (4),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk_clk                (clk),
    .reset_reset_n          (reset_n),
    .freeze_req             (freeze_req),
    .unfreeze_req           (unfreeze_req),
    .pr_done                (pr_done),
    .frozen                 (frozen),
    .busy                   (busy),
    .timeout_err            (timeout_err),
    .persona_reset_n        (persona_reset_n),
    .pr_handshake_stop_req  (stop_req),
    .pr_handshake_stop_ack  (stop_ack),
    .pr_handshake_start_req (start_req),
    .pr_handshake_start_ack (start_ack),
    .s_waitrequest          (s_waitrequest),
    .s_readdata             (s_readdata),
    .s_readdatavalid        (s_readdatavalid),
    .s_address              (s_address),
    .s_writedata            (s_writedata),
    .s_byteenable           (s_byteenable),
    .s_read                 (s_read),
    .s_write                (s_write),
    .s_burstcount           (s_burstcount),
    .m_waitrequest          (m_waitrequest),
    .m_readdata             (m_readdata),
    .m_readdatavalid        (m_readdatavalid),
    .m_address              (m_address),
    .m_writedata            (m_writedata),
    .m_byteenable           (m_byteenable),
    .m_read                 (m_read),
    .m_write                (m_write),
    .m_burstcount           (m_burstcount)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- region responder ----------------
  typedef struct {
    logic [63:0] d;
    int          due;
  } rsp_t;

  logic [63:0] mem [logic [15:0]];
  rsp_t        pend [$];
  bit          hold = 1'b0;

  always @(negedge clk) begin
    if (m_write && !m_waitrequest)
      mem[m_address] = m_writedata;
    if (m_read && !m_waitrequest)
      pend.push_back('{mem.exists(m_address) ? mem[m_address] : 64'h0, cyc + 3});
  end

  always @(posedge clk) begin
    #2;
    if (pend.size() > 0 && !hold && pend[0].due <= cyc) begin
      m_readdatavalid = 1'b1;
      m_readdata      = pend[0].d;
      void'(pend.pop_front());
    end else begin
      m_readdatavalid = 1'b0;
      m_readdata      = '0;
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [63:0] expq [$];

  always @(negedge clk) begin
    if (reset_n && s_readdatavalid) begin
      if (expq.size() == 0) begin
        chk("unexpected_rvalid", 64'd1, 64'd0);
      end else begin
        chk("host_rdata", s_readdata, expq.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic host_rd(input logic [15:0] a, input logic [63:0] exp, input bit push);
    bit ok = 1'b0;
    s_read    = 1'b1;
    s_address = a;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!s_waitrequest) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("rd_accept_timeout", 64'd0, 64'd1);
    else if (push) expq.push_back(exp);
    @(posedge clk); #1;
    s_read = 1'b0;
  endtask

  task automatic host_wr(input logic [15:0] a, input logic [63:0] d);
    bit ok = 1'b0;
    s_write     = 1'b1;
    s_address   = a;
    s_writedata = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!s_waitrequest) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wr_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    s_write = 1'b0;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return frozen;
      1:       return stop_req;
      2:       return start_req;
      default: return busy;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val, input int maxc, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (sig(sel) === val) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 64'(ok), 64'd1);
  endtask

  task automatic pulse_freeze(input logic also_unfreeze);
    @(posedge clk); #1;
    freeze_req   = 1'b1;
    unfreeze_req = also_unfreeze;
    @(posedge clk); #1;
    freeze_req   = 1'b0;
    unfreeze_req = 1'b0;
  endtask

  task automatic do_unfreeze();
    @(posedge clk); #1; pr_done = 1'b1;
    @(posedge clk); #1; pr_done = 1'b0; unfreeze_req = 1'b1;
    @(posedge clk); #1; unfreeze_req = 1'b0;
    @(negedge clk);
    chk("start_req_raised", 64'(start_req), 64'd1);
    chk("start_frozen_low", 64'(frozen), 64'd0);
    chk("start_persona_rst", 64'(persona_reset_n), 64'd1);
    chk("start_busy", 64'(busy), 64'd1);
    repeat (3) @(posedge clk);
    #1 start_ack = 1'b1;
    wait_sig(2, 1'b0, 20, "start_req_drop");
    chk("run_busy_low", 64'(busy), 64'd0);
    chk("run_frozen_low", 64'(frozen), 64'd0);
    @(posedge clk); #1 start_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n_stop;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_frozen", 64'(frozen), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    chk("rst_persona_rst_n", 64'(persona_reset_n), 64'd1);
    chk("rst_stop_req", 64'(stop_req), 64'd0);
    chk("rst_start_req", 64'(start_req), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // 1: pass-through and outstanding-limit stall
    host_wr(16'h0010, 64'h1234);
    host_wr(16'h0020, 64'hABCD);
    host_rd(16'h0010, 64'h1234, 1'b1);
    repeat (5) @(posedge clk);
    #1 hold = 1'b1;
    host_rd(16'h0010, 64'h1234, 1'b1);
    host_rd(16'h0020, 64'hABCD, 1'b1);
    host_rd(16'h0030, 64'h0,    1'b1);
    host_rd(16'h0020, 64'hABCD, 1'b1);
    s_read    = 1'b1;
    s_address = 16'h0020;
    @(negedge clk);
    chk("full_stall_wait", 64'(s_waitrequest), 64'd1);
    chk("full_stall_mread", 64'(m_read), 64'd0);
    @(posedge clk); #1 hold = 1'b0;
    host_rd(16'h0020, 64'hABCD, 1'b1);
    repeat (10) @(posedge clk);
    #1;

    // 2: clean freeze with two reads in flight; simultaneous unfreeze loses
    hold = 1'b1;
    host_rd(16'h0010, 64'h1234, 1'b1);
    host_rd(16'h0020, 64'hABCD, 1'b1);
    pulse_freeze(1'b1);
    @(negedge clk);
    chk("stop_req_raised", 64'(stop_req), 64'd1);
    chk("stop_busy", 64'(busy), 64'd1);
    chk("stop_host_stall", 64'(s_waitrequest), 64'd1);
    repeat (4) @(posedge clk);
    #1 stop_ack = 1'b1;
    wait_sig(1, 1'b0, 20, "stop_req_drop");
    chk("drain_busy", 64'(busy), 64'd1);
    chk("drain_not_frozen", 64'(frozen), 64'd0);
    @(posedge clk); #1;
    stop_ack = 1'b0;
    hold     = 1'b0;
    wait_sig(0, 1'b1, 50, "frozen_after_drain");
    chk("frozen_persona_rst", 64'(persona_reset_n), 64'd0);
    chk("frozen_busy_low", 64'(busy), 64'd0);
    chk("clean_no_timeout", 64'(timeout_err), 64'd0);
    @(posedge clk); #1;

    // 3: frozen host access
    host_rd(16'h0000, FRZ, 1'b1);
    @(negedge clk);
    chk("frz_rd_latency", 64'(s_readdatavalid), 64'd1);
    @(posedge clk); #1;
    s_write     = 1'b1;
    s_address   = 16'h0010;
    s_writedata = 64'hBAD;
    @(negedge clk);
    chk("frz_wr_blocked", 64'(m_write), 64'd0);
    chk("frz_wr_accepted", 64'(s_waitrequest), 64'd0);
    @(posedge clk); #1 s_write = 1'b0;

    // 5: unfreeze gated by pr_done
    unfreeze_req = 1'b1;
    @(posedge clk); #1 unfreeze_req = 1'b0;
    @(negedge clk);
    chk("unfreeze_ignored_frozen", 64'(frozen), 64'd1);
    chk("unfreeze_ignored_start", 64'(start_req), 64'd0);
    do_unfreeze();
    host_rd(16'h0010, 64'h1234, 1'b1);
    repeat (6) @(posedge clk);
    #1;

    // 4: stop_ack never comes, drain never completes
    hold = 1'b1;
    host_rd(16'h0030, 64'h0, 1'b0);
    pulse_freeze(1'b0);
    n_stop = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (stop_req) n_stop++;
      else break;
    end
    chk("stop_timeout_cycles", 64'(n_stop), 64'd100);
    wait_sig(0, 1'b1, 150, "frozen_after_timeout");
    chk("timeout_err_set", 64'(timeout_err), 64'd1);
    @(posedge clk); #1 hold = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    do_unfreeze();
    chk("timeout_err_sticky", 64'(timeout_err), 64'd1);

    // 6: reset during STOP_REQ
    @(posedge clk); #1 hold = 1'b1;
    host_rd(16'h0010, 64'h0, 1'b0);
    pulse_freeze(1'b0);
    @(negedge clk);
    chk("pre_rst_stop_req", 64'(stop_req), 64'd1);
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    pend.delete();
    hold = 1'b0;
    @(negedge clk);
    chk("midrst_stop_req", 64'(stop_req), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_persona_rst", 64'(persona_reset_n), 64'd1);
    chk("midrst_timeout_clr", 64'(timeout_err), 64'd0);
    chk("midrst_outst", 64'(dut.outst), 64'd0);
    @(posedge clk); #1;
    host_rd(16'h0020, 64'hABCD, 1'b1);
    repeat (10) @(negedge clk);
    chk("scoreboard_drained", 64'(expq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
